// File: rtl/pc_fetch_ctrl_if.sv
// Request/response bundle between the pipeline hazard sources and the fetch sequencer.
interface pc_fetch_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             branch_taken;
  logic             jump_req;
  logic             hazard_stall;
  logic             imem_ready;
  logic             halt_req;
  logic             PCWrite;
  logic [1:0]       PCSel;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             halted;
  logic             stall_timeout;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output branch_taken, jump_req, hazard_stall, imem_ready, halt_req,
    input  PCWrite, PCSel, flush_if_id, flush_id_ex, halted, stall_timeout, redirect_cnt
  );

  modport slave (
    input  branch_taken, jump_req, hazard_stall, imem_ready, halt_req,
    output PCWrite, PCSel, flush_if_id, flush_id_ex, halted, stall_timeout, redirect_cnt
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch sequencer: arbitrates redirects, stalls, wait states and halt
// into Mealy PCWrite/PCSel/flush controls, with stall-timeout and redirect bookkeeping.
module pc_fetch_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_STALL    = 15,
  parameter int unsigned CNT_W        = 16
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_ctrl_if.slave bus
);
  localparam int unsigned FC_W = 3;
  localparam int unsigned SC_W = 8;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [1:0] SEL_PC1 = 2'd0;
  localparam logic [1:0] SEL_ALU = 2'd1;
  localparam logic [1:0] SEL_JMP = 2'd2;

  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1);
  localparam logic [SC_W-1:0] STALL_LIM  = SC_W'(MAX_STALL);
  localparam bit              HAS_FLUSH  = (FLUSH_CYCLES > 0);

  logic [1:0]       state, state_nx;
  logic [FC_W-1:0]  flush_cnt, flush_cnt_nx;
  logic [SC_W-1:0]  stall_cnt, stall_cnt_nx;
  logic             active;
  logic             run_rules;
  logic             pc_write_c;
  logic [1:0]       pc_sel_c;
  logic             flush_if_id_c;
  logic             flush_id_ex_c;
  logic             stall_timeout_q;
  logic [CNT_W-1:0] redirect_cnt_q;

  // Next-state and Mealy output decode
  always_comb begin
    state_nx      = state;
    flush_cnt_nx  = flush_cnt;
    stall_cnt_nx  = '0;
    run_rules     = 1'b0;
    pc_write_c    = 1'b1;
    pc_sel_c      = SEL_PC1;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;

    case (state)
      S_RUN: run_rules = 1'b1;
      S_WAIT: begin
        if (bus.branch_taken || bus.imem_ready) run_rules = 1'b1;
        else                                    pc_write_c = 1'b0;
      end
      S_FLUSH: begin
        flush_if_id_c = 1'b1;
        if (!bus.imem_ready) begin
          pc_write_c = 1'b0;
        end else if (flush_cnt == FLUSH_LAST) begin
          flush_cnt_nx = '0;
          state_nx     = S_RUN;
        end else begin
          flush_cnt_nx = flush_cnt + FC_W'(1);
        end
      end
      default: begin
        pc_write_c    = 1'b0;
        flush_if_id_c = 1'b1;
        if (!bus.halt_req) state_nx = S_RUN;
      end
    endcase

    // Shared RUN arbitration, also used by WAIT once memory is ready or a branch resolves
    if (run_rules) begin
      state_nx = S_RUN;
      if (bus.branch_taken) begin
        pc_sel_c      = SEL_ALU;
        flush_if_id_c = 1'b1;
        flush_id_ex_c = 1'b1;
        if (HAS_FLUSH) state_nx = S_FLUSH;
      end else if (bus.jump_req) begin
        pc_sel_c      = SEL_JMP;
        flush_if_id_c = 1'b1;
        if (HAS_FLUSH) state_nx = S_FLUSH;
      end else if (bus.halt_req) begin
        pc_write_c    = 1'b0;
        flush_if_id_c = 1'b1;
        state_nx      = S_HALT;
      end else if (bus.hazard_stall) begin
        pc_write_c    = 1'b0;
        flush_id_ex_c = 1'b1;
        stall_cnt_nx  = (stall_cnt == '1) ? stall_cnt : stall_cnt + SC_W'(1);
      end else if (!bus.imem_ready) begin
        pc_write_c = 1'b0;
        state_nx   = S_WAIT;
      end
    end
  end

  // State and bookkeeping registers; the first edge after reset only arms the controller
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active          <= 1'b0;
      state           <= S_RUN;
      flush_cnt       <= '0;
      stall_cnt       <= '0;
      stall_timeout_q <= 1'b0;
      redirect_cnt_q  <= '0;
    end else if (!active) begin
      active <= 1'b1;
    end else begin
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
      stall_cnt <= stall_cnt_nx;
      if (stall_cnt_nx >= STALL_LIM) stall_timeout_q <= 1'b1;
      if (pc_write_c && (pc_sel_c != SEL_PC1) && (redirect_cnt_q != '1))
        redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
    end
  end

  assign bus.PCWrite       = active & pc_write_c;
  assign bus.PCSel         = active ? pc_sel_c : SEL_PC1;
  assign bus.flush_if_id   = active & flush_if_id_c;
  assign bus.flush_id_ex   = active & flush_id_ex_c;
  assign bus.halted        = (state == S_HALT);
  assign bus.stall_timeout = stall_timeout_q;
  assign bus.redirect_cnt  = redirect_cnt_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench: two configurations of the fetch sequencer driven in parallel and
// checked every cycle against a countdown/queue-free behavioural model.
module tb_pc_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic br = 1'b0, jp = 1'b0, hz = 1'b0, rdy = 1'b1, hl = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.CNT_W(16)) bus_a ();
  pc_fetch_ctrl_if #(.CNT_W(2))  bus_b ();

  assign bus_a.branch_taken = br;
  assign bus_a.jump_req     = jp;
  assign bus_a.hazard_stall = hz;
  assign bus_a.imem_ready   = rdy;
  assign bus_a.halt_req     = hl;
  assign bus_b.branch_taken = br;
  assign bus_b.jump_req     = jp;
  assign bus_b.hazard_stall = hz;
  assign bus_b.imem_ready   = rdy;
  assign bus_b.halt_req     = hl;

  pc_fetch_ctrl #(.FLUSH_CYCLES(1), .MAX_STALL(15), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave));
  pc_fetch_ctrl #(.FLUSH_CYCLES(0), .MAX_STALL(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave));

  typedef struct {
    bit started;
    bit halt;
    bit wt;
    int flush_left;
    int stall_run;
    bit tmo;
    int redirects;
  } mdl_t;

  typedef struct {
    int pcw, sel, fif, fie, halted, tmo, rcnt;
  } exp_t;

  mdl_t ma, mb, ma_nx, mb_nx;

  // One cycle of the behavioural model: expected outputs now, model after the edge
  function automatic void step(input int fc, input int ms, input int cw, input mdl_t m,
                               output exp_t e, output mdl_t n);
    bit stalled;
    stalled = 1'b0;
    n = m;
    e = '{default: 0};
    if (!m.started) begin
      n.started = 1'b1;
      return;
    end
    e.halted = int'(m.halt);
    e.tmo    = int'(m.tmo);
    e.rcnt   = (m.redirects > (1 << cw) - 1) ? (1 << cw) - 1 : m.redirects;
    e.pcw    = 1;
    if (m.halt) begin
      e.pcw = 0; e.fif = 1;
      if (!hl) n.halt = 1'b0;
    end else if (m.flush_left > 0) begin
      e.fif = 1;
      if (!rdy) e.pcw = 0;
      else      n.flush_left = m.flush_left - 1;
    end else if (m.wt && !br && !rdy) begin
      e.pcw = 0;
    end else begin
      n.wt = 1'b0;
      if (br) begin
        e.sel = 1; e.fif = 1; e.fie = 1; n.flush_left = fc;
      end else if (jp) begin
        e.sel = 2; e.fif = 1; n.flush_left = fc;
      end else if (hl) begin
        e.pcw = 0; e.fif = 1; n.halt = 1'b1;
      end else if (hz) begin
        e.pcw = 0; e.fie = 1; stalled = 1'b1;
      end else if (!rdy) begin
        e.pcw = 0; n.wt = 1'b1;
      end
    end
    n.stall_run = stalled ? m.stall_run + 1 : 0;
    if (n.stall_run >= ms) n.tmo = 1'b1;
    if (e.sel != 0 && e.pcw != 0) n.redirects = m.redirects + 1;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input int pcw, input int sel,
                     input int fif, input int fie, input int hlt, input int tmo, input int rc);
    chk({tag, ".PCWrite"}, pcw, e.pcw);
    chk({tag, ".PCSel"}, sel, e.sel);
    chk({tag, ".flush_if_id"}, fif, e.fif);
    chk({tag, ".flush_id_ex"}, fie, e.fie);
    chk({tag, ".halted"}, hlt, e.halted);
    chk({tag, ".stall_timeout"}, tmo, e.tmo);
    chk({tag, ".redirect_cnt"}, rc, e.rcnt);
  endtask

  // Model compare on every falling edge, both configurations
  always @(negedge clk) begin
    exp_t ea, eb;
    step(1, 15, 16, ma, ea, ma_nx);
    step(0, 3, 2, mb, eb, mb_nx);
    cmp("mdl_a", ea, int'(bus_a.PCWrite), int'(bus_a.PCSel), int'(bus_a.flush_if_id),
        int'(bus_a.flush_id_ex), int'(bus_a.halted), int'(bus_a.stall_timeout),
        int'(bus_a.redirect_cnt));
    cmp("mdl_b", eb, int'(bus_b.PCWrite), int'(bus_b.PCSel), int'(bus_b.flush_if_id),
        int'(bus_b.flush_id_ex), int'(bus_b.halted), int'(bus_b.stall_timeout),
        int'(bus_b.redirect_cnt));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = ma_nx;
      mb = mb_nx;
    end
  end

  task automatic apply(input logic b, input logic j, input logic h, input logic r, input logic q);
    br = b; jp = j; hz = h; rdy = r; hl = q;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      apply(0, 0, 0, 1, 0);
      tick();
    end
  endtask

  initial begin
    // Reset and arming edge: controller silent
    apply(0, 0, 0, 1, 0);
    chk("rst_pcwrite", int'(bus_a.PCWrite), 0);
    tick();
    rst = 1'b0;
    apply(0, 0, 0, 1, 0);
    chk("arm_pcwrite", int'(bus_a.PCWrite), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 1, 0);
      chk("idle_pcwrite", int'(bus_a.PCWrite), 1);
      chk("idle_pcsel", int'(bus_a.PCSel), 0);
      chk("idle_rcnt", int'(bus_a.redirect_cnt), 0);
      tick();
    end

    // Branch with one flush cycle
    apply(1, 0, 0, 1, 0);
    chk("br_pcsel", int'(bus_a.PCSel), 1);
    chk("br_fif", int'(bus_a.flush_if_id), 1);
    chk("br_fie", int'(bus_a.flush_id_ex), 1);
    tick();
    apply(0, 0, 0, 1, 0);
    chk("flush_fif", int'(bus_a.flush_if_id), 1);
    chk("flush_fie", int'(bus_a.flush_id_ex), 0);
    chk("flush_pcsel", int'(bus_a.PCSel), 0);
    tick();
    apply(0, 0, 0, 1, 0);
    chk("post_fif", int'(bus_a.flush_if_id), 0);
    chk("post_rcnt", int'(bus_a.redirect_cnt), 1);
    tick();

    // Branch and jump together: branch wins, counted once
    apply(1, 1, 0, 1, 0);
    chk("brjp_pcsel", int'(bus_a.PCSel), 1);
    tick();
    idle(1);
    apply(0, 0, 0, 1, 0);
    chk("brjp_rcnt", int'(bus_a.redirect_cnt), 2);
    tick();

    // Jump held across an instruction-memory wait window
    apply(0, 0, 0, 0, 0);
    chk("wait0_pcwrite", int'(bus_a.PCWrite), 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      apply(0, 1, 0, 0, 0);
      chk("waitj_pcwrite", int'(bus_a.PCWrite), 0);
      tick();
    end
    apply(0, 1, 0, 1, 0);
    chk("jmp_pcsel", int'(bus_a.PCSel), 2);
    chk("jmp_pcwrite", int'(bus_a.PCWrite), 1);
    tick();
    idle(1);

    // Load-use stall for MAX_STALL cycles, then sticky timeout
    for (int i = 0; i < 15; i++) begin
      apply(0, 0, 1, 1, 0);
      chk("stall_pcwrite", int'(bus_a.PCWrite), 0);
      chk("stall_fie", int'(bus_a.flush_id_ex), 1);
      chk("stall_tmo_low", int'(bus_a.stall_timeout), 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 1, 0);
      chk("tmo_sticky", int'(bus_a.stall_timeout), 1);
      tick();
    end

    // Halt for four cycles, then release
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 1, 1);
      chk("halt_pcwrite", int'(bus_a.PCWrite), 0);
      chk("halt_halted", int'(bus_a.halted), (i == 0) ? 0 : 1);
      tick();
    end
    apply(0, 0, 0, 1, 0);
    chk("rel_pcwrite", int'(bus_a.PCWrite), 0);
    tick();
    apply(0, 0, 0, 1, 0);
    chk("resume_pcwrite", int'(bus_a.PCWrite), 1);
    chk("resume_halted", int'(bus_a.halted), 0);
    tick();

    // Reset asserted in the middle of HALT
    apply(0, 0, 0, 1, 1);
    tick();
    apply(0, 0, 0, 1, 1);
    chk("midhalt_halted", int'(bus_a.halted), 1);
    rst = 1'b1;
    #1;
    chk("rst_halted", int'(bus_a.halted), 0);
    chk("rst_tmo", int'(bus_a.stall_timeout), 0);
    chk("rst_rcnt", int'(bus_a.redirect_cnt), 0);
    tick();
    rst = 1'b0;
    idle(2);

    // Five redirects saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      apply(1, 0, 0, 1, 0);
      tick();
      idle(2);
    end
    apply(0, 0, 0, 1, 0);
    chk("sat_rcnt_b", int'(bus_b.redirect_cnt), 3);
    chk("sat_rcnt_a", int'(bus_a.redirect_cnt), 5);
    tick();

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        apply(0, 0, 0, 1, 0);
        tick();
        rst = 1'b0;
      end
      apply(logic'($urandom_range(0, 9) == 0), logic'($urandom_range(0, 7) == 0),
            logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 4) != 0),
            logic'($urandom_range(0, 19) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
